// File: rtl/fp_dispatch.sv
// fp_dispatch: hands one FP add/sub request at a time to an external adder,
// waits for completion or timeout, and returns the result with status flags.
//
// Parameter : TIMEOUT - WAIT cycles without add_done before the request is abandoned
// Macro     : FP_DISPATCH_NEGATE_EN - issue subtraction as addition of a negated op2
// Ports     : clk, n_rst (async, active-low)
//             req_valid/req_ready, req_mode, req_op1, req_op2   host request
//             rsp_valid/rsp_ready, rsp_result, rsp_overflow,
//             rsp_timeout                                       host response
//             add_start, mode, op1, op2                         adder command
//             add_result, add_done, add_overflow                adder status
module fp_dispatch #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_timeout,
    output logic        add_start,
    output logic        mode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] add_result,
    input  logic        add_done,
    input  logic        add_overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [4:0]  wait_cnt;
    logic [4:0]  wait_cnt_inc;
    logic        timeout_hit;
    logic        accept;
    logic        wait_exit;
    logic [31:0] op2_in;
    logic        mode_in;

`ifdef FP_DISPATCH_NEGATE_EN
    assign op2_in  = req_mode ? {~req_op2[31], req_op2[30:0]} : req_op2;
    assign mode_in = 1'b0;
`else
    assign op2_in  = req_op2;
    assign mode_in = req_mode;
`endif

    assign req_ready = (state == IDLE);
    assign add_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // Timeout fires on the WAIT cycle whose increment reaches TIMEOUT,
    // so exactly TIMEOUT WAIT cycles elapse; add_done still wins there.
    assign wait_cnt_inc = wait_cnt + 5'd1;
    assign timeout_hit  = (state == WAIT) && !add_done &&
                          (wait_cnt_inc == 5'(TIMEOUT));
    assign wait_exit    = (state == WAIT) && (add_done || timeout_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op1  <= '0;
            op2  <= '0;
            mode <= 1'b0;
        end else if (accept) begin
            op1  <= req_op1;
            op2  <= op2_in;
            mode <= mode_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !add_done) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else if (wait_exit) begin
            if (add_done) begin
                rsp_result   <= add_result;
                rsp_overflow <= add_overflow || (&add_result[30:23]);
                rsp_timeout  <= 1'b0;
            end else begin
                rsp_result   <= 32'h7FC0_0000;
                rsp_overflow <= 1'b0;
                rsp_timeout  <= 1'b1;
            end
        end
    end

endmodule
